// File: rtl/calf_inject_queue.sv
// Injection-side node interface for the CALF bufferless router: builds stamped control flits,
// queues them and offers the head on router port 4. Optional counters: CALF_INJ_STATS_EN.
module calf_inject_queue #(
  parameter logic [3:0]  NODE_ID = 4'd0,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enq_valid,
  output logic                       enq_ready,
  input  logic [127:0]               enq_payload,
  input  logic [3:0]                 enq_mshr,
  input  logic [3:0]                 enq_dest,
  output logic [143:0]               port4_ci,
  input  logic                       port4_ready,
  input  logic                       port4_ack,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic [31:0]                stat_injected,
  output logic [31:0]                stat_stall
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [143:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_d;
  logic [2:0]    seq;
  logic          push, pop, presented;
  logic [143:0]  new_flit;

  assign enq_ready = (count != CW'(DEPTH));
  assign push      = enq_valid && enq_ready;
  assign presented = (count != '0) && port4_ready;
  // Built flits always carry the valid bit, so "presented" equals "port4_ci nonzero".
  assign pop       = port4_ack && presented;
  assign port4_ci  = presented ? mem[rd_ptr] : 144'h0;
  assign occupancy = count;
  assign new_flit  = {enq_payload, enq_mshr, 1'b1, seq, NODE_ID, enq_dest};

  always_comb begin
    count_d = count;
    unique case ({push, pop})
      2'b10:   count_d = count + CW'(1);
      2'b01:   count_d = count - CW'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      seq    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        seq    <= seq + 3'd1;
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count_d;
    end
  end

  // Storage is never cleared; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= new_flit;
  end

`ifdef CALF_INJ_STATS_EN
  logic [31:0] injected_q, stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      injected_q <= '0;
      stall_q    <= '0;
    end else begin
      if (pop) injected_q <= injected_q + 32'd1;
      if ((count != '0) && !pop) stall_q <= stall_q + 32'd1;
    end
  end

  assign stat_injected = injected_q;
  assign stat_stall    = stall_q;
`else
  assign stat_injected = 32'h0;
  assign stat_stall    = 32'h0;
`endif

endmodule

// File: tb/tb_calf_inject_queue.sv
// Randomised and directed bench for calf_inject_queue against a queue-based reference model.
module tb_calf_inject_queue;

  localparam int unsigned DEPTH = 4;
  localparam logic [3:0]  NID   = 4'd5;

  logic         clk = 1'b0;
  logic         rst;
  logic         enq_valid;
  logic         enq_ready;
  logic [127:0] enq_payload;
  logic [3:0]   enq_mshr;
  logic [3:0]   enq_dest;
  logic [143:0] port4_ci;
  logic         port4_ready;
  logic         port4_ack;
  logic [2:0]   occupancy;
  logic [31:0]  stat_injected;
  logic [31:0]  stat_stall;

  calf_inject_queue #(.NODE_ID(NID), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .enq_valid     (enq_valid),
    .enq_ready     (enq_ready),
    .enq_payload   (enq_payload),
    .enq_mshr      (enq_mshr),
    .enq_dest      (enq_dest),
    .port4_ci      (port4_ci),
    .port4_ready   (port4_ready),
    .port4_ack     (port4_ack),
    .occupancy     (occupancy),
    .stat_injected (stat_injected),
    .stat_stall    (stat_stall)
  );

  always #5 clk = ~clk;

  int unsigned  n_checks = 0;
  int unsigned  n_fail   = 0;

  // Reference model state
  logic [143:0] mq[$];
  int unsigned  mseq;
  logic [31:0]  m_inj, m_stall;

  task automatic check(input string tag, input logic [143:0] got, input logic [143:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [127:0] p, input logic [3:0] m,
                       input logic [3:0] d, input logic r, input logic a, input logic rs);
    enq_valid = v; enq_payload = p; enq_mshr = m; enq_dest = d;
    port4_ready = r; port4_ack = a; rst = rs;
    #1;
  endtask

  task automatic idle(input logic r, input logic a);
    drive(1'b0, 128'h0, 4'h0, 4'h0, r, a, 1'b0);
  endtask

  // Compare every output with the model, then advance model and DUT by one clock.
  task automatic tick();
    logic [143:0] exp_ci;
    logic         exp_rdy, pres, pop, push;
    exp_rdy = (mq.size() != DEPTH);
    pres    = (mq.size() != 0) && port4_ready;
    exp_ci  = pres ? mq[0] : 144'h0;
    check("port4_ci", port4_ci, exp_ci);
    check("enq_ready", 144'(enq_ready), 144'(exp_rdy));
    check("occupancy", 144'(occupancy), 144'(mq.size()));
`ifdef CALF_INJ_STATS_EN
    check("stat_injected", 144'(stat_injected), 144'(m_inj));
    check("stat_stall", 144'(stat_stall), 144'(m_stall));
`else
    check("stat_injected", 144'(stat_injected), 144'h0);
    check("stat_stall", 144'(stat_stall), 144'h0);
`endif
    pop  = port4_ack && pres;
    push = enq_valid && exp_rdy;
    if (rst) begin
      mq.delete();
      mseq = 0; m_inj = 0; m_stall = 0;
    end else begin
      if (mq.size() != 0 && !pop) m_stall++;
      if (pop) begin
        void'(mq.pop_front());
        m_inj++;
      end
      if (push) begin
        mq.push_back({enq_payload, enq_mshr, 1'b1, 3'(mseq), NID, enq_dest});
        mseq = (mseq + 1) % 8;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(1'b0, 128'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
  endtask

  logic [31:0]  stall_before;
  logic [127:0] rp;

  initial begin
    mseq = 0; m_inj = 0; m_stall = 0;
    @(negedge clk);
    do_reset();
    idle(1'b1, 1'b0);
    check("reset_ci", port4_ci, 144'h0);
    check("reset_occ", 144'(occupancy), 144'h0);
    check("reset_rdy", 144'(enq_ready), 144'h1);

    // Single flit
    drive(1'b1, 128'h0123456789abcdef0123456789abcdef, 4'h1, 4'h7, 1'b1, 1'b0, 1'b0);
    check("same_cycle_ci", port4_ci, 144'h0);
    tick();
    idle(1'b1, 1'b1);
    check("single_flit", port4_ci, 144'h0123456789abcdef0123456789abcdef1857);
    tick();
    idle(1'b1, 1'b0);
    check("after_ack_ci", port4_ci, 144'h0);
    check("after_ack_occ", 144'(occupancy), 144'h0);
    tick();

    // Fill with router not ready, then refuse a fifth
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, {4{$urandom}}, 4'(i), 4'(i), 1'b0, 1'b1, 1'b0);
      tick();
    end
    idle(1'b0, 1'b0);
    check("full_occ", 144'(occupancy), 144'h4);
    check("full_rdy", 144'(enq_ready), 144'h0);
    check("full_ci_hidden", port4_ci, 144'h0);
    tick();
    // Full with simultaneous enqueue and ack
    drive(1'b1, {4{$urandom}}, 4'h9, 4'h9, 1'b1, 1'b1, 1'b0);
    tick();
    idle(1'b0, 1'b0);
    check("full_pop_occ", 144'(occupancy), 144'h3);
    check("full_pop_rdy", 144'(enq_ready), 144'h1);
    tick();

    // Sequence wrap over 9 flits
    do_reset();
    for (int k = 0; k < 9; k++) begin
      drive(1'b1, {4{$urandom}}, 4'h2, 4'h3, 1'b1, 1'b1, 1'b0);
      if (k > 0) check("seq_wrap", 144'(port4_ci[11:8]), 144'(8 + ((k - 1) % 8)));
      tick();
    end
    idle(1'b1, 1'b1);
    check("seq_wrap_last", 144'(port4_ci[11:8]), 144'h8);
    tick();

    // Spurious ack while empty, then reset with two held flits
    idle(1'b1, 1'b1);
    tick();
    idle(1'b1, 1'b0);
    check("spurious_occ", 144'(occupancy), 144'h0);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, {4{$urandom}}, 4'h4, 4'h1, 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 128'h0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b1);
    tick();
    idle(1'b1, 1'b0);
    check("rst_occ", 144'(occupancy), 144'h0);
    check("rst_ci", port4_ci, 144'h0);
    drive(1'b1, {4{$urandom}}, 4'h6, 4'h2, 1'b1, 1'b0, 1'b0);
    tick();
    idle(1'b1, 1'b1);
    check("rst_seq0", 144'(port4_ci[10:8]), 144'h0);
    tick();

    // Statistics scenario
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, {4{$urandom}}, 4'h1, 4'h2, 1'b0, 1'b0, 1'b0);
      tick();
    end
    idle(1'b0, 1'b0);
    stall_before = stat_stall;
    for (int i = 0; i < 5; i++) tick();
    idle(1'b0, 1'b0);
    check("stall_hold", 144'(stat_stall - stall_before), 144'(`ifdef CALF_INJ_STATS_EN 5 `else 0 `endif));
    for (int i = 0; i < 3; i++) begin
      idle(1'b1, 1'b1);
      tick();
    end
    idle(1'b0, 1'b0);
    check("stat_inj_3", 144'(stat_injected), 144'(`ifdef CALF_INJ_STATS_EN 3 `else 0 `endif));
    tick();

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      rp = {$urandom, $urandom, $urandom, $urandom};
      drive(1'($urandom_range(0, 99) < 60), rp, 4'($urandom), 4'($urandom),
            1'($urandom_range(0, 99) < 70), 1'($urandom_range(0, 99) < 50),
            1'($urandom_range(0, 99) < 2));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
